// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM generator with a shared frame period.
// Host writes go to shadow widths and become active at the frame boundary.
module servo_pwm_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned CNT_BITS      = 20,
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned MAX_PULSE     = 100000,
    parameter int unsigned DEFAULT_PULSE = 75000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [CNT_BITS-1:0] wr_data,
    input  logic [CHANNELS-1:0] ch_enable,
    output logic [CHANNELS-1:0] servo_out,
    output logic                frame_start,
    output logic                wr_clamped,
    output logic                wr_err
);

    localparam logic [CNT_BITS-1:0] LAST  = CNT_BITS'(PERIOD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] MIN_W = CNT_BITS'(MIN_PULSE);
    localparam logic [CNT_BITS-1:0] MAX_W = CNT_BITS'(MAX_PULSE);
    localparam logic [CNT_BITS-1:0] DEF_W = CNT_BITS'(DEFAULT_PULSE);
    localparam logic [CNT_BITS-1:0] ONE   = CNT_BITS'(1);
    localparam logic [4:0]          CH_N  = 5'(CHANNELS);

    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                run_q, run_d;
    logic [CNT_BITS-1:0] shadow_q [CHANNELS];
    logic [CNT_BITS-1:0] shadow_d [CHANNELS];
    logic [CNT_BITS-1:0] act_w_q  [CHANNELS];
    logic [CNT_BITS-1:0] act_w_d  [CHANNELS];
    logic [CHANNELS-1:0] act_en_q, act_en_d;
    logic [CHANNELS-1:0] servo_q, servo_d;
    logic                frame_start_q, frame_start_d;
    logic                wr_clamped_q, wr_clamped_d;
    logic                wr_err_q, wr_err_d;

    logic                addr_ok;
    logic                boundary;
    logic                wr_clip;
    logic [CNT_BITS-1:0] wr_val;

    always_comb begin
        addr_ok = {1'b0, wr_addr} < CH_N;
        wr_clip = (wr_data < MIN_W) || (wr_data > MAX_W);
        if (wr_data < MIN_W) begin
            wr_val = MIN_W;
        end else if (wr_data > MAX_W) begin
            wr_val = MAX_W;
        end else begin
            wr_val = wr_data;
        end
    end

    // run_q is low only in the cycle following a reset edge, so the
    // first non-reset edge starts frame cycle 0 without a boundary load.
    always_comb begin
        boundary = run_q && (cnt_q == LAST);
        run_d    = 1'b1;
        if (!run_q || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + ONE;
        end

        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_en && (wr_addr == 4'(i))) begin
                shadow_d[i] = wr_val;
            end
            act_w_d[i] = boundary ? shadow_d[i] : act_w_q[i];
        end

        act_en_d = boundary ? ch_enable : act_en_q;

        // Outputs are computed for the cycle about to start.
        for (int i = 0; i < CHANNELS; i++) begin
            servo_d[i] = act_en_d[i] && (cnt_d < act_w_d[i]);
        end

        frame_start_d = (cnt_d == '0);
        wr_clamped_d  = wr_en && addr_ok && wr_clip;
        wr_err_d      = wr_en && !addr_ok;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= '0;
            run_q         <= 1'b0;
            act_en_q      <= '0;
            servo_q       <= '0;
            frame_start_q <= 1'b0;
            wr_clamped_q  <= 1'b0;
            wr_err_q      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= DEF_W;
                act_w_q[i]  <= DEF_W;
            end
        end else begin
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            act_en_q      <= act_en_d;
            servo_q       <= servo_d;
            frame_start_q <= frame_start_d;
            wr_clamped_q  <= wr_clamped_d;
            wr_err_q      <= wr_err_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                act_w_q[i]  <= act_w_d[i];
            end
        end
    end

    assign servo_out   = servo_q;
    assign frame_start = frame_start_q;
    assign wr_clamped  = wr_clamped_q;
    assign wr_err      = wr_err_q;

endmodule
